// File: rtl/mario_sprite_fetch.sv
// Sprite fetch for the Mario character: box test, ROM address generation with
// horizontal mirroring, and a vsync-paced walk animation FSM selecting the ROM.
module mario_sprite_fetch #(
  parameter int unsigned SPRITE_W = 21,
  parameter int unsigned SPRITE_H = 41,
  parameter int unsigned ANIM_DIV = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] MarioX,
  input  logic [9:0] MarioY,
  input  logic       moving,
  input  logic       facing_left,
  output logic [9:0] read_address,
  output logic [1:0] frame_sel,
  output logic       sprite_on
);

  localparam int unsigned PW = 10;
  localparam int unsigned SW = 11;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    WALK1 = 2'd1,
    WALK2 = 2'd2,
    WALK3 = 2'd3
  } anim_state_e;

  anim_state_e   state_q;
  logic [CW-1:0] tick_q;
  logic          vs_q;
  logic          frame_evt_c;

  logic [SW-1:0] draw_x_ext, draw_y_ext, mario_x_ext, mario_y_ext;
  logic [SW-1:0] x_end, y_end;
  logic          in_box_c;
  logic [PW-1:0] col_c, row_c, col_eff_c;
  logic [PW-1:0] read_address_d, read_address_q;
  logic          sprite_on_d, sprite_on_q;

  assign frame_evt_c = vs_q & ~vs;

  // Widened box bounds so sprites near the right/bottom edge never wrap.
  always_comb begin
    draw_x_ext  = SW'(DrawX);
    draw_y_ext  = SW'(DrawY);
    mario_x_ext = SW'(MarioX);
    mario_y_ext = SW'(MarioY);
    x_end       = mario_x_ext + SW'(SPRITE_W);
    y_end       = mario_y_ext + SW'(SPRITE_H);
    in_box_c    = (draw_x_ext >= mario_x_ext) && (draw_x_ext < x_end) &&
                  (draw_y_ext >= mario_y_ext) && (draw_y_ext < y_end);
  end

  // Offsets only matter in-box, where they are small and exact modulo 2^10.
  always_comb begin
    col_c          = DrawX - MarioX;
    row_c          = DrawY - MarioY;
    col_eff_c      = facing_left ? (PW'(SPRITE_W - 1) - col_c) : col_c;
    sprite_on_d    = in_box_c;
    read_address_d = '0;
    if (in_box_c) begin
      read_address_d = (row_c * PW'(SPRITE_W)) + col_eff_c;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address_q <= '0;
      sprite_on_q    <= 1'b0;
      vs_q           <= 1'b1;
    end else begin
      read_address_q <= read_address_d;
      sprite_on_q    <= sprite_on_d;
      vs_q           <= vs;
    end
  end

  // Animation FSM: advances only on vsync falling edges.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= STAND;
      tick_q  <= '0;
    end else if (frame_evt_c) begin
      if (!moving) begin
        state_q <= STAND;
        tick_q  <= '0;
      end else if (state_q == STAND) begin
        state_q <= WALK1;
        tick_q  <= '0;
      end else if (tick_q == CW'(ANIM_DIV - 1)) begin
        tick_q <= '0;
        case (state_q)
          WALK1:   state_q <= WALK2;
          WALK2:   state_q <= WALK3;
          default: state_q <= WALK1;
        endcase
      end else begin
        tick_q <= tick_q + CW'(1);
      end
    end
  end

  assign read_address = read_address_q;
  assign sprite_on    = sprite_on_q;
  assign frame_sel    = state_q;

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Randomized self-checking bench for mario_sprite_fetch against an arithmetic
// reference model (box/address from geometry, animation from a frame count).
module tb_mario_sprite_fetch;

  localparam int W   = 21;
  localparam int H   = 41;
  localparam int DIV = 6;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       vs;
  logic [9:0] DrawX, DrawY, MarioX, MarioY;
  logic       moving, facing_left;
  logic [9:0] read_address;
  logic [1:0] frame_sel;
  logic       sprite_on;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: frames walked since walking began (0 = standing), last vs.
  int   walk_frames;
  logic vs_prev_m;

  mario_sprite_fetch #(.SPRITE_W(W), .SPRITE_H(H), .ANIM_DIV(DIV)) dut (
    .Clk(Clk), .Reset(Reset), .vs(vs),
    .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
    .moving(moving), .facing_left(facing_left),
    .read_address(read_address), .frame_sel(frame_sel), .sprite_on(sprite_on)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_sel();
    if (walk_frames == 0) return 0;
    return 1 + ((walk_frames - 1) / DIV) % 3;
  endfunction

  // One clock: predict from the inputs presented to this edge, then compare.
  task automatic do_cycle();
    int dx, dy, mx, my, col, e_on, e_addr;
    dx = int'(DrawX); dy = int'(DrawY); mx = int'(MarioX); my = int'(MarioY);
    e_on = (dx >= mx && dx < mx + W && dy >= my && dy < my + H) ? 1 : 0;
    col  = facing_left ? (W - 1 - (dx - mx)) : (dx - mx);
    e_addr = e_on ? (dy - my) * W + col : 0;
    if (Reset) begin
      e_on = 0; e_addr = 0; walk_frames = 0; vs_prev_m = 1'b1;
    end else begin
      if (vs_prev_m && !vs) walk_frames = moving ? walk_frames + 1 : 0;
      vs_prev_m = vs;
    end
    @(posedge Clk); #1;
    check("sprite_on", int'(sprite_on), e_on);
    check("read_address", int'(read_address), e_addr);
    check("frame_sel", int'(frame_sel), exp_sel());
  endtask

  task automatic frame_pulse();
    vs = 1'b0; do_cycle();
    vs = 1'b1; do_cycle();
  endtask

  task automatic set_pix(input int mx, input int my, input int dx, input int dy, input bit fl);
    MarioX = 10'(mx); MarioY = 10'(my); DrawX = 10'(dx); DrawY = 10'(dy); facing_left = fl;
  endtask

  task automatic rand_pix();
    int mx, my;
    mx = int'($urandom_range(0, 639));
    my = int'($urandom_range(0, 479));
    set_pix(mx, my,
            (mx + int'($urandom_range(0, 30)) + 635) % 640,
            (my + int'($urandom_range(0, 50)) + 475) % 480,
            1'($urandom_range(0, 1)));
  endtask

  initial begin
    walk_frames = 0; vs_prev_m = 1'b1;
    Reset = 1'b1; vs = 1'b1; moving = 1'b0;
    set_pix(100, 200, 105, 203, 1'b0);
    #1;
    check("reset_addr", int'(read_address), 0);
    check("reset_on", int'(sprite_on), 0);
    check("reset_sel", int'(frame_sel), 0);
    do_cycle(); do_cycle();
    @(posedge Clk); #1; Reset = 1'b0;
    vs_prev_m = 1'b1;

    // Directed address and box-edge cases.
    set_pix(100, 200, 105, 203, 1'b0); do_cycle();
    check("right_addr68", int'(read_address), 68);
    set_pix(100, 200, 105, 203, 1'b1); do_cycle();
    check("mirror_addr78", int'(read_address), 78);
    set_pix(100, 200, 121, 203, 1'b0); do_cycle();
    check("xedge_off", int'(sprite_on), 0);
    set_pix(100, 200, 120, 240, 1'b0); do_cycle();
    check("corner_addr860", int'(read_address), 860);
    set_pix(100, 200, 120, 241, 1'b0); do_cycle();
    set_pix(100, 200, 99, 203, 1'b0); do_cycle();
    set_pix(630, 300, 639, 300, 1'b0); do_cycle();
    check("screen_edge_on", int'(sprite_on), 1);
    check("screen_edge_addr9", int'(read_address), 9);
    set_pix(1000, 470, 5, 475, 1'b0); do_cycle();

    // Walk animation with moving held high.
    moving = 1'b1;
    for (int f = 1; f <= 19; f++) begin
      rand_pix();
      frame_pulse();
      if (f == 1)  check("anim_f1", int'(frame_sel), 1);
      if (f == 7)  check("anim_f7", int'(frame_sel), 2);
      if (f == 13) check("anim_f13", int'(frame_sel), 3);
      if (f == 19) check("anim_f19", int'(frame_sel), 1);
    end

    // Reach WALK2, drop moving between events, then take the next fall.
    for (int f = 0; f < 6; f++) frame_pulse();
    check("walk2_before_stop", int'(frame_sel), 2);
    moving = 1'b0;
    do_cycle(); do_cycle();
    check("stop_hold", int'(frame_sel), 2);
    frame_pulse();
    check("stop_stand", int'(frame_sel), 0);

    // Reach WALK3, then assert Reset mid-cycle.
    moving = 1'b1;
    for (int f = 0; f < 13; f++) frame_pulse();
    check("walk3_reached", int'(frame_sel), 3);
    set_pix(100, 200, 105, 203, 1'b0); do_cycle();
    check("on_before_reset", int'(sprite_on), 1);
    #2 Reset = 1'b1;
    #1;
    check("async_sel", int'(frame_sel), 0);
    check("async_on", int'(sprite_on), 0);
    do_cycle();
    @(posedge Clk); #1; Reset = 1'b0;
    vs_prev_m = 1'b1;
    frame_pulse();
    check("post_reset_walk1", int'(frame_sel), 1);

    // Randomized mixed traffic.
    for (int i = 0; i < 600; i++) begin
      rand_pix();
      if ($urandom_range(0, 19) == 0) moving = ~moving;
      vs = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
